// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path and the cache arrays.
package icache_pkg;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_FILL = 2'd2,
        IC_DONE = 2'd3
    } ic_state_e;

    localparam int IC_WORDS_PER_LINE = 4;
    localparam int IC_DATA_W         = 32;
    localparam int IC_BEAT_W         = $clog2(IC_WORDS_PER_LINE);
    localparam int IC_OFFSET_W       = $clog2(IC_WORDS_PER_LINE * IC_DATA_W / 8);
    localparam int IC_PERF_CNT_W     = 32;

    // Byte-offset width of a line for an arbitrary geometry.
    function automatic int ic_offset_w(input int words, input int data_w);
        return $clog2(words * data_w / 8);
    endfunction

endpackage

// File: rtl/icache_perf_cnt.sv
// Saturating miss and stall-cycle counters; only built when ICACHE_PERF_CNT_EN is defined.
`ifdef ICACHE_PERF_CNT_EN
module icache_perf_cnt
    import icache_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_miss,
    input  logic                     i_stall,
    output logic [IC_PERF_CNT_W-1:0] o_miss_cnt,
    output logic [IC_PERF_CNT_W-1:0] o_stall_cnt
);

    logic [IC_PERF_CNT_W-1:0] r_miss_cnt;
    logic [IC_PERF_CNT_W-1:0] r_stall_cnt;

    function automatic logic [IC_PERF_CNT_W-1:0] sat_inc(input logic [IC_PERF_CNT_W-1:0] v);
        return (&v) ? v : v + IC_PERF_CNT_W'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_miss_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (i_miss)  r_miss_cnt  <= sat_inc(r_miss_cnt);
            if (i_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign o_miss_cnt  = r_miss_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule
`endif

// File: rtl/icache_refill_ctrl.sv
// I-cache miss handler: stalls fetch, reads the missing line and fills data/tag arrays.
// Optional ICACHE_PERF_CNT_EN adds miss_cnt/stall_cnt outputs.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_valid,
    input  logic              hit,
    input  logic              pc_src,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_tag_we
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [IC_PERF_CNT_W-1:0] miss_cnt,
    output logic [IC_PERF_CNT_W-1:0] stall_cnt
`endif
);

    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W  = ic_offset_w(WORDS_PER_LINE, DATA_W);
    localparam int WB_W   = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    ic_state_e         r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [ADDR_W-1:0] r_line_base;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_req;
    logic              w_miss;
    logic              w_beat;
    logic              w_last;

    // Wrong-path lookups (pc_src) never start a refill.
    assign w_miss = (r_state == IC_IDLE) & fetch_valid & ~hit & ~pc_src;
    assign w_beat = (r_state == IC_FILL) & mem_rvalid;
    assign w_last = w_beat & (r_beat == LAST_BEAT);

    assign stall       = w_miss | (r_state != IC_IDLE);
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign fill_we     = w_beat;
    assign fill_addr   = w_beat ? (r_line_base | (ADDR_W'(r_beat) << WB_W)) : '0;
    assign fill_data   = w_beat ? mem_rdata : '0;
    assign fill_tag_we = w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IC_IDLE;
            r_beat      <= '0;
            r_line_base <= '0;
            r_mem_addr  <= '0;
            r_mem_req   <= 1'b0;
        end else begin
            case (r_state)
                IC_IDLE: begin
                    if (w_miss) begin
                        r_line_base <= fetch_pc & LINE_MASK;
                        r_mem_addr  <= fetch_pc & LINE_MASK;
                        r_mem_req   <= 1'b1;
                        r_beat      <= '0;
                        r_state     <= IC_REQ;
                    end
                end
                IC_REQ: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= '0;
                        r_state    <= IC_FILL;
                    end
                end
                IC_FILL: begin
                    if (w_beat) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (w_last) r_state <= IC_DONE;
                    end
                end
                default: r_state <= IC_IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    icache_perf_cnt u_perf_cnt (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_miss      (w_miss),
        .i_stall     (stall),
        .o_miss_cnt  (miss_cnt),
        .o_stall_cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl; exercises the perf counters when ICACHE_PERF_CNT_EN is defined.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        fetch_valid, hit, pc_src;
    logic        stall, mem_req, mem_ack, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        fill_we, fill_tag_we;
    logic [31:0] fill_addr, fill_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] miss_cnt, stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Observations recorded by run_refill for the calling test to judge.
    int          obs_stall, obs_req, obs_fill, obs_tag, obs_tag_idx, obs_spur;
    bit          obs_drop, obs_addr_moved, obs_timeout;
    logic [31:0] obs_req_addr;
    logic [31:0] obs_addr [0:15];
    logic [31:0] obs_data [0:15];

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .hit         (hit),
        .pc_src      (pc_src),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .fill_we     (fill_we),
        .fill_addr   (fill_addr),
        .fill_data   (fill_data),
        .fill_tag_we (fill_tag_we)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .miss_cnt    (miss_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_valid = 1'b0;
        hit         = 1'b0;
        pc_src      = 1'b0;
        mem_ack     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
    endtask

    // Memory model plus fetch stage for one complete miss; records, does not judge.
    task automatic run_refill(input logic [31:0] pc, input int ack_delay, input int gap,
                              input bit spur, input logic [31:0] dbase);
        int wait_n, gap_n, sent, cyc;
        bit acked, got_tag, beat_now, ack_now, stall_seen;
        wait_n = 0; gap_n = 0; sent = 0; cyc = 0;
        acked = 0; got_tag = 0; stall_seen = 0;
        obs_stall = 0; obs_req = 0; obs_fill = 0; obs_tag = 0; obs_tag_idx = -1; obs_spur = 0;
        obs_drop = 0; obs_addr_moved = 0; obs_timeout = 0; obs_req_addr = '0;
        while (1) begin
            fetch_valid = 1'b1; fetch_pc = pc; hit = got_tag; pc_src = 1'b0;
            mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            beat_now = 0; ack_now = 0;
            if (mem_req) begin
                if (wait_n == ack_delay) begin
                    mem_ack = 1'b1; ack_now = 1;
                end else begin
                    wait_n++;
                    if (spur) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
                end
            end else if (acked && sent < 4 && !got_tag) begin
                if (gap_n == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = dbase + 32'(sent);
                    sent++; gap_n = gap; beat_now = 1;
                end else begin
                    gap_n--;
                end
            end
            #1;
            if (stall) begin obs_stall++; stall_seen = 1; end
            else if (stall_seen && !got_tag) obs_drop = 1;
            if (mem_req) begin
                if (obs_req == 0) obs_req_addr = mem_addr;
                else if (mem_addr !== obs_req_addr) obs_addr_moved = 1;
                obs_req++;
            end
            if (fill_we) begin
                if (!beat_now) obs_spur++;
                if (obs_fill < 16) begin
                    obs_addr[obs_fill] = fill_addr;
                    obs_data[obs_fill] = fill_data;
                end
                obs_fill++;
            end
            if (fill_tag_we) begin obs_tag++; obs_tag_idx = obs_fill - 1; end
            if (!stall && got_tag) break;
            if (fill_tag_we) got_tag = 1;
            cyc++;
            if (cyc >= 100) begin obs_timeout = 1; break; end
            next_cycle();
            if (ack_now) acked = 1;
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        fetch_pc = 32'h0000_0100;
        apply_reset();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem got req=%b addr=%h want 0/0", mem_req, mem_addr); end
        total++; if ({fill_we, fill_tag_we} !== 2'b00 || fill_addr !== 32'h0 || fill_data !== 32'h0) begin
            bad++; $display("FAIL reset_fill got we=%b tag=%b addr=%h data=%h want all 0", fill_we, fill_tag_we, fill_addr, fill_data); end
`ifdef ICACHE_PERF_CNT_EN
        total++; if (miss_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_perf got miss=%0d stall=%0d want 0/0", miss_cnt, stall_cnt); end
`endif
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_single_miss();
        run_refill(32'h0000_0014, 0, 0, 0, 32'hA000_0000);
        total++; if (obs_timeout) begin bad++; $display("FAIL single_timeout got=timeout want=done"); end
        total++; if (obs_req_addr !== 32'h10) begin bad++; $display("FAIL single_mem_addr got=%h want=00000010", obs_req_addr); end
        total++; if (obs_req !== 1) begin bad++; $display("FAIL single_req_cycles got=%0d want=1", obs_req); end
        total++; if (obs_fill !== 4) begin bad++; $display("FAIL single_fill_count got=%0d want=4", obs_fill); end
        for (int k = 0; k < 4 && k < obs_fill; k++) begin
            total++; if (obs_addr[k] !== 32'h10 + 32'(4 * k)) begin bad++; $display("FAIL single_fill_addr[%0d] got=%h want=%h", k, obs_addr[k], 32'h10 + 32'(4 * k)); end
            total++; if (obs_data[k] !== 32'hA000_0000 + 32'(k)) begin bad++; $display("FAIL single_fill_data[%0d] got=%h want=%h", k, obs_data[k], 32'hA000_0000 + 32'(k)); end
        end
        total++; if (obs_tag !== 1 || obs_tag_idx !== 3) begin bad++; $display("FAIL single_tag got pulses=%0d beat=%0d want 1/3", obs_tag, obs_tag_idx); end
        total++; if (obs_stall !== 7) begin bad++; $display("FAIL single_stall_cycles got=%0d want=7", obs_stall); end
    endtask

    task automatic test_pc_src();
        fetch_valid = 1'b1; hit = 1'b0; pc_src = 1'b1; fetch_pc = 32'h0000_0200;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL pcsrc_stall got=%b want=0", stall); end
        next_cycle();
        pc_src = 1'b0; hit = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL pcsrc_req got req=%b stall=%b want 0/0", mem_req, stall); end
        next_cycle();
        idle_inputs();
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hit_req got=%b want=0", mem_req); end
        next_cycle();
    endtask

    task automatic test_delayed_ack();
        run_refill(32'h1000_0038, 3, 2, 0, 32'hC0DE_0000);
        total++; if (obs_timeout) begin bad++; $display("FAIL delay_timeout got=timeout want=done"); end
        total++; if (obs_req !== 4 || obs_req_addr !== 32'h1000_0030) begin bad++; $display("FAIL delay_req got cycles=%0d addr=%h want 4/10000030", obs_req, obs_req_addr); end
        total++; if (obs_addr_moved) begin bad++; $display("FAIL delay_addr_stable got=moved want=stable"); end
        total++; if (obs_fill !== 4) begin bad++; $display("FAIL delay_fill_count got=%0d want=4", obs_fill); end
        total++; if (obs_fill > 3 && obs_addr[3] !== 32'h1000_003C) begin bad++; $display("FAIL delay_last_addr got=%h want=1000003c", obs_addr[3]); end
        total++; if (obs_drop || obs_stall !== 16) begin bad++; $display("FAIL delay_stall got cycles=%0d drop=%0d want 16/0", obs_stall, obs_drop); end
    endtask

    task automatic test_spurious();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        total++; if (fill_we !== 1'b0) begin bad++; $display("FAIL spur_idle_we got=%b want=0", fill_we); end
        next_cycle();
        run_refill(32'h0000_0044, 2, 0, 1, 32'h5500_0000);
        total++; if (obs_spur !== 0) begin bad++; $display("FAIL spur_req_we got=%0d want=0", obs_spur); end
        total++; if (obs_fill !== 4 || obs_tag_idx !== 3) begin bad++; $display("FAIL spur_fill got count=%0d tagbeat=%0d want 4/3", obs_fill, obs_tag_idx); end
        total++; if (obs_addr[0] !== 32'h40 || obs_data[0] !== 32'h5500_0000) begin bad++; $display("FAIL spur_first_beat got addr=%h data=%h want 00000040/55000000", obs_addr[0], obs_data[0]); end
        total++; if (obs_stall !== 9) begin bad++; $display("FAIL spur_stall got=%0d want=9", obs_stall); end
    endtask

    task automatic test_reset_mid_fill();
        bit tag_seen;
        tag_seen = 0;
        fetch_valid = 1'b1; hit = 1'b0; fetch_pc = 32'h0000_0084;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_miss_stall got=%b want=1", stall); end
        next_cycle();
        fetch_valid = 1'b0; mem_ack = 1'b1;
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin bad++; $display("FAIL rst_req got req=%b addr=%h want 1/00000080", mem_req, mem_addr); end
        next_cycle();
        mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1;
        #1; tag_seen |= fill_tag_we;
        next_cycle();
        mem_rdata = 32'h2;
        #1; tag_seen |= fill_tag_we;
        total++; if (fill_we !== 1'b1 || fill_addr !== 32'h84) begin bad++; $display("FAIL rst_beat1 got we=%b addr=%h want 1/00000084", fill_we, fill_addr); end
        next_cycle();
        mem_rvalid = 1'b0; rst_n = 1'b0;
        #1; tag_seen |= fill_tag_we;
        next_cycle();
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h3;
        #1; tag_seen |= fill_tag_we;
        total++; if ({stall, mem_req, fill_we, fill_tag_we} !== 4'b0000 || mem_addr !== 32'h0 || fill_addr !== 32'h0 || fill_data !== 32'h0) begin
            bad++; $display("FAIL rst_outputs got stall=%b req=%b addr=%h we=%b faddr=%h fdata=%h tag=%b want all 0", stall, mem_req, mem_addr, fill_we, fill_addr, fill_data, fill_tag_we); end
        total++; if (tag_seen) begin bad++; $display("FAIL rst_no_tag got=tag_write want=none"); end
        next_cycle();
        idle_inputs();
        run_refill(32'h0000_0088, 0, 0, 0, 32'h7700_0000);
        total++; if (obs_fill !== 4 || obs_addr[0] !== 32'h80) begin bad++; $display("FAIL rst_restart got count=%0d addr0=%h want 4/00000080", obs_fill, obs_addr[0]); end
        total++; if (obs_tag_idx !== 3 || obs_stall !== 7) begin bad++; $display("FAIL rst_restart_tag got tagbeat=%0d stall=%0d want 3/7", obs_tag_idx, obs_stall); end
    endtask

`ifdef ICACHE_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        run_refill(32'h0000_0100, 0, 0, 0, 32'h0);
        run_refill(32'h0000_0208, 0, 0, 0, 32'h0);
        run_refill(32'h0000_030C, 0, 0, 0, 32'h0);
        total++; if (miss_cnt !== 32'd3) begin bad++; $display("FAIL perf_miss got=%0d want=3", miss_cnt); end
        total++; if (stall_cnt !== 32'd21) begin bad++; $display("FAIL perf_stall got=%0d want=21", stall_cnt); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        fetch_pc = '0;
        idle_inputs();
        next_cycle();
        test_reset();
        test_single_miss();
        test_pc_src();
        test_delayed_ack();
        test_spurious();
        test_reset_mid_fill();
`ifdef ICACHE_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling controller for the instruction-fetch stage. When the fetch stage reports a cache miss for a valid, non-redirected fetch, it stalls the PC, requests the missing line from instruction memory, and writes the returned words into the cache data array. On the final word it also writes the tag and valid bit, then releases the stall so fetch can re-look-up and hit. It sits between `fetch_module` (PC, `hit`, `pc_src`) and the instruction-memory port.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, instruction/word width
- `WORDS_PER_LINE`, 4, words per cache line; power of 2, ≥2
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `fetch_pc`  in  ADDR_W  PC currently being looked up
- `fetch_valid`  in  1  fetch stage is issuing a lookup this cycle
- `hit`  in  1  tag/valid match for `fetch_pc`
- `pc_src`  in  1  branch redirect this cycle; current fetch is wrong-path
- `stall`  out  1  freeze PC and fetch register
- `mem_req`  out  1  line-read request to memory
- `mem_addr`  out  ADDR_W  line-aligned address of the request
- `mem_ack`  in  1  memory accepted the request
- `mem_rvalid`  in  1  one data beat valid
- `mem_rdata`  in  DATA_W  data beat, in ascending word order
- `fill_we`  out  1  write one word into the data array
- `fill_addr`  out  ADDR_W  byte address of the word being written
- `fill_data`  out  DATA_W  word being written
- `fill_tag_we`  out  1  write tag and set valid for the line at `fill_addr`

## Operation
- Miss condition: `miss = fetch_valid & ~hit & ~pc_src`, evaluated only in IDLE. A miss in the same cycle as `pc_src` is ignored because it belongs to the wrong path.
- States: IDLE → REQ → FILL → DONE → IDLE.
  - IDLE: on `miss`, latch `line_base = fetch_pc` with the low log2(WORDS_PER_LINE·DATA_W/8) bits cleared. Clear the beat counter. Go to REQ.
  - REQ: `mem_req`=1 and `mem_addr`=`line_base`, held stable until `mem_ack`. Go to FILL on `mem_ack`.
  - FILL: each `mem_rvalid` gives `fill_we`=1, `fill_data`=`mem_rdata`, and `fill_addr`=`line_base` + beat·(DATA_W/8). The beat counter increments and wraps at WORDS_PER_LINE. On beat WORDS_PER_LINE−1, `fill_tag_we`=1 in the same cycle and the FSM goes to DONE.
  - DONE: one cycle, no writes. Then IDLE.
- `stall = miss (in IDLE) | (state != IDLE)`. The stall is asserted combinationally in the miss cycle.
- `mem_rvalid` outside FILL is ignored. Memory never returns a beat in the cycle of `mem_ack`.
- A refill is never aborted. `pc_src` while not in IDLE has no effect on the FSM; the fetched line is valid data either way.
- Fill outputs are combinational from the FSM state and the memory inputs. `mem_req` and `mem_addr` come from registers.
- Reset values: all outputs 0, state IDLE, beat counter 0, `line_base` 0. Reset during REQ or FILL returns to IDLE next edge. No tag write occurs, so a partially filled line stays invalid.

## Timing
- Miss detected at edge T (IDLE): `stall`=1 in cycle T, `mem_req`=1 from T+1.
- Ack at cycle A: FILL from A+1. With back-to-back beats, `fill_tag_we` falls at A+WORDS_PER_LINE (earliest).
- DONE one cycle after the last beat. `stall`=0 in the following IDLE cycle, where the re-lookup hits.
- Minimum miss penalty, with `mem_ack` in the first REQ cycle and beats back-to-back: WORDS_PER_LINE+3 stall cycles.
- Gaps between beats simply extend FILL; `stall` stays 1 throughout.

## Configuration
- `ICACHE_PERF_CNT_EN` defined: adds outputs `miss_cnt` (out, 32) and `stall_cnt` (out, 32).
  - `miss_cnt` increments on each IDLE→REQ transition.
  - `stall_cnt` increments on every cycle with `stall`=1.
  - Both saturate at all-ones and reset to 0.
- Macro undefined: these ports and the counter logic are absent.

## Structure
- Shared package `icache_pkg` holds:
  - the FSM state enum (`IC_IDLE`, `IC_REQ`, `IC_FILL`, `IC_DONE`);
  - localparams for offset width and beat-counter width (`$clog2(WORDS_PER_LINE)`), shared with the cache arrays.
- One sub-module: `icache_perf_cnt` (two saturating counters), instantiated only under `ICACHE_PERF_CNT_EN`.

## Test plan
- Single miss, `fetch_pc`=0x0000_0014, WORDS_PER_LINE=4:
  - `mem_addr`=0x10; fills at 0x10, 0x14, 0x18, 0x1C with the returned data;
  - `fill_tag_we` on the 0x1C beat;
  - `stall` high exactly 7 cycles with immediate ack and back-to-back beats.
- Miss with `pc_src`=1 in the same cycle → no `mem_req`, `stall` stays 0.
- `mem_ack` delayed 3 cycles and 2-cycle gaps between beats → `mem_addr` stable during REQ; exactly 4 `fill_we` pulses; `stall` continuous until after DONE.
- Spurious `mem_rvalid` in IDLE and REQ → no `fill_we`; beat count unaffected.
- `rst_n`=0 after the second FILL beat → next cycle IDLE with all outputs 0, no `fill_tag_we`. A subsequent miss restarts from beat 0.
- `ICACHE_PERF_CNT_EN`: three misses at 7 stall cycles each → `miss_cnt`=3, `stall_cnt`=21.
